// File: rtl/ma_pkg.sv
// ma_pkg: shared FSM state type and default watchdog limit for the memory access unit
package ma_pkg;
    typedef enum logic {IDLE, WAIT} state_e;
    localparam int MA_TIMEOUT = 16;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: pipeline-side controls, data-memory port and MA/WB results of the memory stage
interface mem_access_unit_if;
    logic        MemRd, MemWr, MemSrc;
    logic [31:0] addr, store_data, wb_data;
    logic [4:0]  rd_in;
    logic        RegWr_in;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
    logic        stall;
    logic [4:0]  wb_rd;
    logic        wb_RegWr;
    logic [31:0] wb_value;
    logic        misalign, bus_err;
    modport master (
        input  MemRd, MemWr, MemSrc, addr, store_data, wb_data, rd_in, RegWr_in, mem_rdata, mem_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, stall, wb_rd, wb_RegWr, wb_value, misalign, bus_err
    );
    modport slave (
        output MemRd, MemWr, MemSrc, addr, store_data, wb_data, rd_in, RegWr_in, mem_rdata, mem_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, stall, wb_rd, wb_RegWr, wb_value, misalign, bus_err
    );
endinterface

// File: rtl/ma_watchdog.sv
// ma_watchdog: counts WAIT cycles and flags the last one allowed before an access is aborted
module ma_watchdog import ma_pkg::*; #(
    parameter int TIMEOUT = MA_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT) + 1;
    logic [W-1:0] cnt_q, cnt_d;
    assign cnt_d = clear ? '0 : enable ? cnt_q + W'(1) : cnt_q;
    assign expired = enable && cnt_q == W'(TIMEOUT - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage issuing one data-memory access at a time, with misalign/timeout handling and the MA/WB register
module mem_access_unit import ma_pkg::*; #(
    parameter int TIMEOUT = MA_TIMEOUT
) (
    input logic clk,
    input logic rst,
    mem_access_unit_if.master bus
);
    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, value_q, value_d;
    logic [4:0]  rd_q, rd_d;
    logic        we_q, we_d, reg_wr_q, reg_wr_d, mis_q, mis_d, err_q, err_d;
    logic        access, accept, in_wait, expired, stall;
    assign access  = bus.MemRd | bus.MemWr;
    assign accept  = state_q == IDLE && access && bus.addr[1:0] == 2'b00;
    assign in_wait = state_q == WAIT;
    ma_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk(clk), .rst(rst), .clear(accept), .enable(in_wait), .expired(expired)
    );
    // Every path that does not write back a result leaves a bubble: rd/RegWr cleared, value held
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rd_d     = 5'd0;
        reg_wr_d = 1'b0;
        value_d  = value_q;
        mis_d    = 1'b0;
        err_d    = 1'b0;
        stall    = 1'b0;
        if (!in_wait) begin
            if (accept) begin
                state_d = WAIT;
                addr_d  = bus.addr;
                we_d    = bus.MemWr;
                wdata_d = bus.MemSrc ? bus.wb_data : bus.store_data;
                stall   = 1'b1;
            end else if (access) begin
                mis_d = 1'b1;
            end else begin
                rd_d     = bus.rd_in;
                reg_wr_d = bus.RegWr_in;
                value_d  = bus.addr;
            end
        end else if (bus.mem_ready) begin
            state_d  = IDLE;
            rd_d     = bus.rd_in;
            reg_wr_d = bus.RegWr_in;
            value_d  = we_q ? bus.addr : bus.mem_rdata;
        end else if (expired) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else begin
            stall = 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rd_q     <= '0;
            reg_wr_q <= 1'b0;
            value_q  <= '0;
            mis_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            reg_wr_q <= reg_wr_d;
            value_q  <= value_d;
            mis_q    <= mis_d;
            err_q    <= err_d;
        end
    end
    assign bus.mem_req   = in_wait;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.stall     = stall;
    assign bus.wb_rd     = rd_q;
    assign bus.wb_RegWr  = reg_wr_q;
    assign bus.wb_value  = value_q;
    assign bus.misalign  = mis_q;
    assign bus.bus_err   = err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: transaction-level random and directed checks of the memory stage
module tb_mem_access_unit;
    localparam int TO = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] exp_value = '0;
    mem_access_unit_if bus();
    mem_access_unit #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask
    task automatic check_wb(input logic [31:0] val, input logic [4:0] rd, input logic regwr, input logic mis, input logic err);
        check("wb_value", bus.wb_value, val);
        check("wb_rd", 32'(bus.wb_rd), 32'(rd));
        check("wb_RegWr", 32'(bus.wb_RegWr), 32'(regwr));
        check("misalign", 32'(bus.misalign), 32'(mis));
        check("bus_err", 32'(bus.bus_err), 32'(err));
        check("req_after", 32'(bus.mem_req), 0);
    endtask
    task automatic drive(input bit rd_en, input bit wr_en, input bit src, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] wd, input logic [31:0] rdata, input logic [4:0] rd, input bit regwr);
        bus.MemRd = rd_en; bus.MemWr = wr_en; bus.MemSrc = src; bus.addr = a;
        bus.store_data = sd; bus.wb_data = wd; bus.mem_rdata = rdata; bus.rd_in = rd; bus.RegWr_in = regwr;
    endtask
    // One pipeline instruction; lat = WAIT cycles before mem_ready (lat >= TO never answers)
    task automatic run_op(input bit rd_en, input bit wr_en, input bit src, input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] wd, input logic [31:0] rdata, input logic [4:0] rd, input bit regwr, input int lat);
        int n;
        bit done;
        drive(rd_en, wr_en, src, a, sd, wd, rdata, rd, regwr);
        if (!(rd_en || wr_en) || a[1:0] != 2'b00) begin
            bus.mem_ready = 1'($urandom);
            #1;
            check("stall_noacc", 32'(bus.stall), 0);
            check("req_noacc", 32'(bus.mem_req), 0);
            @(negedge clk);
            bus.mem_ready = 1'b0;
            if (rd_en || wr_en) check_wb(exp_value, 5'd0, 1'b0, 1'b1, 1'b0);
            else begin
                exp_value = a;
                check_wb(exp_value, rd, regwr, 1'b0, 1'b0);
            end
        end else begin
            n = 0;
            done = 1'b0;
            for (int i = 0; i < 40 && !done; i++) begin
                bus.mem_ready = (i == 0) ? 1'($urandom) : (i - 1 == lat);
                #1;
                if (i > 0) begin
                    check("mem_req", 32'(bus.mem_req), 1);
                    check("mem_we", 32'(bus.mem_we), 32'(wr_en));
                    check("mem_addr", bus.mem_addr, a);
                    check("mem_wdata", bus.mem_wdata, src ? wd : sd);
                end
                if (bus.stall) n++;
                else done = 1'b1;
                @(negedge clk);
            end
            bus.mem_ready = 1'b0;
            check("stall_cycles", 32'(n), 32'(lat < TO ? lat + 1 : TO));
            if (lat < TO) begin
                exp_value = wr_en ? a : rdata;
                check_wb(exp_value, rd, regwr, 1'b0, 1'b0);
            end else check_wb(exp_value, 5'd0, 1'b0, 1'b0, 1'b1);
        end
    endtask
    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.mem_ready = 1'b0;
        #2;
        check("rst_req", 32'(bus.mem_req), 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wb_value", bus.wb_value, 0);
        check("rst_wb_RegWr", 32'(bus.wb_RegWr), 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(1, 0, 0, 32'h10, 0, 0, 32'hDEADBEEF, 5'd8, 1, 3);
        run_op(0, 1, 1, 32'h20, 32'h5678, 32'h1234, 32'h0, 5'd0, 0, 0);
        run_op(1, 0, 0, 32'h13, 0, 0, 32'h0, 5'd9, 1, 0);
        run_op(1, 0, 0, 32'h40, 0, 0, 32'hCAFE, 5'd4, 1, 100);
        run_op(0, 0, 0, 32'h55, 0, 0, 32'h0, 5'd3, 1, 0);
        run_op(1, 1, 0, 32'h80, 32'hABCD, 32'h1, 32'h77, 5'd5, 1, 1);
        // Reset in the second WAIT cycle, then a normal load
        drive(1, 0, 0, 32'h44, 0, 0, 32'h0, 5'd7, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.MemRd = 1'b0;
        #1;
        check("rst_wait_req", 32'(bus.mem_req), 0);
        check("rst_wait_stall", 32'(bus.stall), 0);
        check("rst_wait_we", 32'(bus.mem_we), 0);
        check("rst_wait_addr", bus.mem_addr, 0);
        check_wb(32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        exp_value = '0;
        @(negedge clk);
        rst = 1'b0;
        run_op(1, 0, 0, 32'h44, 0, 0, 32'h600D, 5'd7, 1, 2);
        for (int k = 0; k < 40; k++) begin
            int kind, lat;
            logic [31:0] a;
            kind = int'($urandom_range(0, 3));
            a = $urandom;
            a[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            lat = ($urandom_range(0, 7) == 0) ? TO + int'($urandom_range(0, 3)) : int'($urandom_range(0, 5));
            run_op(kind == 1 || kind == 3, kind >= 2, 1'($urandom), a, $urandom, $urandom, $urandom,
                   5'($urandom), 1'($urandom), lat);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
